// File: rtl/hcu_pkg.sv
// Shared types and constants for the multi-cycle hazard control unit.
package hcu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_t;

  // Register x0 is hardwired to zero and never produces a hazard.
  localparam int unsigned REG_X0 = 0;

endpackage

// File: rtl/hcu_mc_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Count qualifying cycles, sticking at all-ones instead of wrapping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hcu_mc.sv
// Hazard control unit for the 3-stage RV32 pipeline: forwarding, load-use
// bubbling, branch flushing and a sequencer that holds Execute for
// variable-latency multi-cycle operations.
module hcu_mc
  import hcu_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int LAT_W  = 6,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] A1_D,
  input  logic [REG_AW-1:0] A2_D,
  input  logic [REG_AW-1:0] A1_E,
  input  logic [REG_AW-1:0] A2_E,
  input  logic [REG_AW-1:0] A3_E,
  input  logic              RegWE_W_E,
  input  logic [REG_AW-1:0] A3_W,
  input  logic              RegWE_E_W,
  input  logic              RegWE_W_W,
  input  logic              mc_start_E,
  input  logic [LAT_W-1:0]  mc_lat_E,
  input  logic              branch_taken_E,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallW,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic              fwdA_E,
  output logic              fwdB_E,
  output logic              mc_busy,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
);

  localparam logic [REG_AW-1:0] X0 = REG_AW'(REG_X0);

  mc_state_t        r_state;
  logic [LAT_W-1:0] r_cnt;
  logic             r_busy;

  logic w_mcStart;
  logic w_mcStall;
  logic w_loadUse;
  logic w_wbWrites;

  // A start is only honoured from IDLE; in DONE the start flag still belongs
  // to the departing op. Latency 0/1 ops behave as single-cycle.
  assign w_mcStart = (r_state == IDLE) && mc_start_E &&
                     (mc_lat_E >= LAT_W'(2)) && !branch_taken_E;
  assign w_mcStall = w_mcStart || (r_state == BUSY);

  assign w_loadUse = RegWE_W_E && (A3_E != X0) &&
                     ((A3_E == A1_D) || (A3_E == A2_D));
  assign w_wbWrites = RegWE_E_W || RegWE_W_W;

  // Sequencer: the start cycle plus the BUSY cycles stall, DONE lets the op
  // leave, so a latency-L op spends exactly L cycles in Execute.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_mcStart) begin
            r_cnt   <= mc_lat_E - LAT_W'(2);
            r_state <= (mc_lat_E == LAT_W'(2)) ? DONE : BUSY;
            r_busy  <= 1'b1;
          end
        end
        BUSY: begin
          r_cnt <= r_cnt - LAT_W'(1);
          if (r_cnt == LAT_W'(1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mc_busy = r_busy;

  // Priority: mc stall over branch over load-use; everything is forced low
  // while reset is asserted so stalls drop immediately.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallW = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    fwdA_E = 1'b0;
    fwdB_E = 1'b0;
    if (!reset) begin
      fwdA_E = w_wbWrites && (A3_W != X0) && (A3_W == A1_E);
      fwdB_E = w_wbWrites && (A3_W != X0) && (A3_W == A2_E);
      if (w_mcStall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushW = 1'b1;
      end else if (branch_taken_E) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (w_loadUse) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  sat_counter #(.W(PERF_W)) u_stallCnt (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_inc   (StallF),
    .o_count (stall_cnt)
  );

  sat_counter #(.W(PERF_W)) u_flushCnt (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_inc   (FlushD || FlushE),
    .o_count (flush_cnt)
  );

endmodule

// File: tb/tb_hcu_mc.sv
// Self-checking bench for hcu_mc: directed scenarios followed by random
// traffic, compared every cycle against a cycle-count reference model.
// A second instance with 3-bit counters exercises saturation.
module tb_hcu_mc;

  typedef struct packed {
    logic [4:0] a1d, a2d, a1e, a2e, a3e, a3w;
    logic       weWE, weEW, weWW, mcs;
    logic [5:0] lat;
    logic       br;
  } stim_t;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] A1_D, A2_D, A1_E, A2_E, A3_E, A3_W;
  logic RegWE_W_E, RegWE_E_W, RegWE_W_W, mc_start_E, branch_taken_E;
  logic [5:0] mc_lat_E;

  logic StallF, StallD, StallE, StallW, FlushD, FlushE, FlushW, fwdA_E, fwdB_E, mc_busy;
  logic [15:0] stall_cnt, flush_cnt;
  logic sStallF, sStallD, sStallE, sStallW, sFlushD, sFlushE, sFlushW, sFwdA, sFwdB, sBusy;
  logic [2:0] sStallCnt, sFlushCnt;

  int total = 0;
  int bad = 0;
  int opLeft = 0;
  int expStall = 0, expFlush = 0, expStallS = 0, expFlushS = 0;

  always #5 clk = ~clk;

  hcu_mc #(.REG_AW(5), .LAT_W(6), .PERF_W(16)) dut (
    .clk(clk), .reset(reset),
    .A1_D(A1_D), .A2_D(A2_D), .A1_E(A1_E), .A2_E(A2_E), .A3_E(A3_E),
    .RegWE_W_E(RegWE_W_E), .A3_W(A3_W), .RegWE_E_W(RegWE_E_W), .RegWE_W_W(RegWE_W_W),
    .mc_start_E(mc_start_E), .mc_lat_E(mc_lat_E), .branch_taken_E(branch_taken_E),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .fwdA_E(fwdA_E), .fwdB_E(fwdB_E), .mc_busy(mc_busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hcu_mc #(.REG_AW(5), .LAT_W(6), .PERF_W(3)) dutSmall (
    .clk(clk), .reset(reset),
    .A1_D(A1_D), .A2_D(A2_D), .A1_E(A1_E), .A2_E(A2_E), .A3_E(A3_E),
    .RegWE_W_E(RegWE_W_E), .A3_W(A3_W), .RegWE_E_W(RegWE_E_W), .RegWE_W_W(RegWE_W_W),
    .mc_start_E(mc_start_E), .mc_lat_E(mc_lat_E), .branch_taken_E(branch_taken_E),
    .StallF(sStallF), .StallD(sStallD), .StallE(sStallE), .StallW(sStallW),
    .FlushD(sFlushD), .FlushE(sFlushE), .FlushW(sFlushW),
    .fwdA_E(sFwdA), .fwdB_E(sFwdB), .mc_busy(sBusy),
    .stall_cnt(sStallCnt), .flush_cnt(sFlushCnt)
  );

  // The same instruction cannot be both a branch and a multi-cycle op.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(mc_start_E && branch_taken_E))
        else $error("[TB] illegal mc_start_E together with branch_taken_E");
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic driveInputs(input stim_t s);
    A1_D = s.a1d; A2_D = s.a2d; A1_E = s.a1e; A2_E = s.a2e; A3_E = s.a3e; A3_W = s.a3w;
    RegWE_W_E = s.weWE; RegWE_E_W = s.weEW; RegWE_W_W = s.weWW;
    mc_start_E = s.mcs; mc_lat_E = s.lat; branch_taken_E = s.br;
  endtask

  function automatic int satInc(input int v, input int maxV);
    return (v < maxV) ? v + 1 : v;
  endfunction

  // One clock cycle: drive after the edge, compare mid-cycle against the
  // model, then advance the model to what the next edge should produce.
  task automatic applyStimulus(input stim_t s);
    logic start, mcSt, lu, sF, sD, sE, fD, fE, fW, fA, fB, busy;
    logic [9:0] exp;
    @(posedge clk);
    #1;
    driveInputs(s);
    @(negedge clk);
    start = (opLeft == 0) && s.mcs && (s.lat >= 2) && !s.br;
    mcSt  = start || (opLeft > 1);
    lu    = s.weWE && (s.a3e != 0) && ((s.a3e == s.a1d) || (s.a3e == s.a2d));
    busy  = (opLeft > 0);
    fA    = (s.weEW || s.weWW) && (s.a3w != 0) && (s.a3w == s.a1e);
    fB    = (s.weEW || s.weWW) && (s.a3w != 0) && (s.a3w == s.a2e);
    sF = 0; sD = 0; sE = 0; fD = 0; fE = 0; fW = 0;
    if (mcSt) begin
      sF = 1; sD = 1; sE = 1; fW = 1;
    end else if (s.br) begin
      fD = 1; fE = 1;
    end else if (lu) begin
      sF = 1; sD = 1; fE = 1;
    end
    exp = {sF, sD, sE, 1'b0, fD, fE, fW, fA, fB, busy};
    checkOutput("ctrl", {22'd0, StallF, StallD, StallE, StallW, FlushD, FlushE, FlushW, fwdA_E, fwdB_E, mc_busy}, {22'd0, exp});
    checkOutput("ctrl_small", {22'd0, sStallF, sStallD, sStallE, sStallW, sFlushD, sFlushE, sFlushW, sFwdA, sFwdB, sBusy}, {22'd0, exp});
    checkOutput("stall_cnt", {16'd0, stall_cnt}, expStall);
    checkOutput("flush_cnt", {16'd0, flush_cnt}, expFlush);
    checkOutput("stall_cnt_small", {29'd0, sStallCnt}, expStallS);
    checkOutput("flush_cnt_small", {29'd0, sFlushCnt}, expFlushS);
    if (start) opLeft = int'(s.lat) - 1;
    else if (opLeft > 0) opLeft--;
    if (sF) begin
      expStall  = satInc(expStall, 65535);
      expStallS = satInc(expStallS, 7);
    end
    if (fD || fE) begin
      expFlush  = satInc(expFlush, 65535);
      expFlushS = satInc(expFlushS, 7);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctrl"}, {22'd0, StallF, StallD, StallE, StallW, FlushD, FlushE, FlushW, fwdA_E, fwdB_E, mc_busy}, 32'd0);
    checkOutput({tag, "_ctrl_small"}, {22'd0, sStallF, sStallD, sStallE, sStallW, sFlushD, sFlushE, sFlushW, sFwdA, sFwdB, sBusy}, 32'd0);
    checkOutput({tag, "_cnt"}, {sStallCnt, sFlushCnt, stall_cnt, flush_cnt}, 32'd0);
  endtask

  function automatic void modelReset();
    opLeft = 0; expStall = 0; expFlush = 0; expStallS = 0; expFlushS = 0;
  endfunction

  initial begin
    stim_t s;
    stim_t z;
    z = '0;

    // Power-on reset with forwarding-friendly inputs to prove gating.
    s = '0; s.a3w = 5'd5; s.weEW = 1'b1; s.a1e = 5'd5;
    reset = 1'b1;
    driveInputs(s);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    driveInputs(z);
    reset = 1'b0;
    modelReset();

    // Forwarding from W to operand A only; then x0 never forwards.
    s = '0; s.a3w = 5'd5; s.weEW = 1'b1; s.a1e = 5'd5; s.a2e = 5'd6;
    applyStimulus(s);
    checkOutput("fwdA_hit", {31'd0, fwdA_E}, 32'd1);
    checkOutput("fwdB_miss", {31'd0, fwdB_E}, 32'd0);
    s = '0; s.weEW = 1'b1;
    applyStimulus(s);
    checkOutput("fwdA_x0", {31'd0, fwdA_E}, 32'd0);

    // Load-use through source port 2, then the load moves on.
    s = '0; s.weWE = 1'b1; s.a3e = 5'd7; s.a2d = 5'd7;
    applyStimulus(s);
    applyStimulus(z);
    checkOutput("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);

    // Latency-4 op held in Execute for four cycles: three stall cycles.
    s = '0; s.mcs = 1'b1; s.lat = 6'd4;
    repeat (4) applyStimulus(s);
    applyStimulus(z);
    checkOutput("mc4_stall_cnt", {16'd0, stall_cnt}, 32'd4);

    // Latency 1 behaves as single-cycle.
    s = '0; s.mcs = 1'b1; s.lat = 6'd1;
    applyStimulus(s);
    applyStimulus(z);
    checkOutput("mc1_stall_cnt", {16'd0, stall_cnt}, 32'd4);

    // Branch together with a load-use: branch flushes, no stall.
    s = '0; s.br = 1'b1; s.weWE = 1'b1; s.a3e = 5'd7; s.a1d = 5'd7;
    applyStimulus(s);
    checkOutput("br_stallF", {31'd0, StallF}, 32'd0);
    checkOutput("br_flushDE", {30'd0, FlushD, FlushE}, 32'd3);
    applyStimulus(z);
    checkOutput("br_flush_cnt", {16'd0, flush_cnt}, 32'd2);

    // Latency-12 op: 11 stalls push the 3-bit counter into saturation.
    s = '0; s.mcs = 1'b1; s.lat = 6'd12;
    repeat (12) applyStimulus(s);
    applyStimulus(z);
    checkOutput("sat_small", {29'd0, sStallCnt}, 32'd7);
    checkOutput("sat_big", {16'd0, stall_cnt}, 32'd15);

    // Reset during the second BUSY cycle of a latency-8 op.
    s = '0; s.mcs = 1'b1; s.lat = 6'd8;
    repeat (3) applyStimulus(s);
    #2;
    reset = 1'b1;
    #1;
    checkAllZero("midop_reset");
    modelReset();
    driveInputs(z);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(z);

    // Random traffic over a small register range to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      s.a1d  = 5'($urandom_range(0, 3));
      s.a2d  = 5'($urandom_range(0, 3));
      s.a1e  = 5'($urandom_range(0, 3));
      s.a2e  = 5'($urandom_range(0, 3));
      s.a3e  = 5'($urandom_range(0, 3));
      s.a3w  = 5'($urandom_range(0, 3));
      s.weWE = ($urandom_range(0, 2) == 0);
      s.weEW = ($urandom_range(0, 1) == 0);
      s.weWW = ($urandom_range(0, 3) == 0);
      s.mcs  = ($urandom_range(0, 5) == 0);
      s.lat  = 6'($urandom_range(0, 9));
      s.br   = !s.mcs && ($urandom_range(0, 5) == 0);
      applyStimulus(s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hcu_mc.md
Name: hcu_mc

Overview:
- Parametrised successor hazard control unit for the 3-stage (Fetch/Decode, Execute, Writeback) RV32 pipeline.
- Generates stall, flush and forwarding controls like the existing single-cycle unit.
- Adds a multi-cycle Execute sequencer (for mul/div-class ops of variable latency), load-use bubbling from both source ports, and saturating performance counters for stall and flush cycles.
- Sits beside the control pipeline registers; all outputs drive the datapath pipeline registers and operand muxes.

Parameters:
- REG_AW, 5, register address width; x0 is never a hazard source.
- LAT_W, 6, width of the multi-cycle latency field; max latency 2**LAT_W-1.
- PERF_W, 16, width of each saturating performance counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- A1_D, A2_D  in  REG_AW  source registers of the instruction in Decode
- A1_E, A2_E  in  REG_AW  source registers of the instruction in Execute
- A3_E  in  REG_AW  destination of the instruction in Execute
- RegWE_W_E  in  1  Execute instruction writes back only in W (load)
- A3_W  in  REG_AW  destination of the instruction in Writeback
- RegWE_E_W, RegWE_W_W  in  1  W-stage instruction writes the register file (either source)
- mc_start_E  in  1  Execute instruction is multi-cycle
- mc_lat_E  in  LAT_W  total Execute cycles for that op
- branch_taken_E  in  1  branch/jump in Execute redirects PC
- StallF, StallD, StallE, StallW  out  1  hold pipeline register
- FlushD, FlushE, FlushW  out  1  clear pipeline register at next edge
- fwdA_E, fwdB_E  out  1  select W-stage result for ALU operand A/B
- mc_busy  out  1  sequencer not IDLE
- stall_cnt, flush_cnt  out  PERF_W  saturating counters

Behaviour:
- Reset (async): state=IDLE, counter=0, stall_cnt=flush_cnt=0. Every stall/flush/fwd output is 0 while reset is high.
- Forwarding (combinational):
  - fwdA_E = (RegWE_E_W|RegWE_W_W) & A3_W!=0 & A3_W==A1_E; fwdB_E likewise with A2_E.
  - Forwarding stays valid during mc stalls.
- Load-use: lu = RegWE_W_E & A3_E!=0 & (A3_E==A1_D | A3_E==A2_D). Response: StallF=StallD=1, FlushE=1 for exactly one cycle.
- Branch: branch_taken_E gives FlushD=FlushE=1 in the same cycle; no stall.
- Sequencer FSM: IDLE, BUSY, DONE.
  - IDLE -> BUSY when mc_start_E & mc_lat_E>=2 & !branch_taken_E. Load cnt=mc_lat_E-2. In that first cycle assert StallF/D/E and FlushW.
  - BUSY: StallF=StallD=StallE=1 and FlushW=1 (bubble into W). cnt-- each cycle. Go to DONE when cnt==0.
  - DONE: no mc stall; the instruction advances to W at the next edge. Return to IDLE. mc_start_E is ignored in DONE, because it still reflects the departing op.
  - Net effect: an op of latency L occupies Execute for exactly L cycles.
  - mc_lat_E of 0 or 1 is treated as single-cycle: no stall, FSM stays IDLE.
- Priority, highest first:
  1. mc stall. Masks load-use and branch; these are re-evaluated when the stall releases, since the inputs are held.
  2. branch_taken_E. Suppresses load-use, because the D instruction is squashed.
  3. load-use.
- StallW is tied to 0 in this generation (port kept for interface compatibility).
- Counters: stall_cnt increments on every cycle with StallF=1; flush_cnt increments on every cycle with FlushD|FlushE. Both saturate at all-ones and never wrap.
- Simultaneous mc_start_E and branch_taken_E is illegal (same instruction). Branch wins, no sequencer start; the bench flags it with an assertion.
- Reset mid-BUSY: returns to IDLE immediately; all stalls drop asynchronously.

Decomposition:
- Package hcu_pkg holds the FSM state enum (IDLE/BUSY/DONE) and the x0 constant.
- Sub-module sat_counter #(W) is instantiated twice for the performance counters.
- FSM, hazard compare and forwarding stay in hcu_mc.

Test Plan:
- Forwarding: A3_W=5, RegWE_E_W=1, A1_E=5, A2_E=6 -> fwdA_E=1, fwdB_E=0. With A3_W=0 and A1_E=0 -> fwdA_E=0.
- Load-use: RegWE_W_E=1, A3_E=7, A2_D=7 -> one cycle of StallF=StallD=FlushE=1; the next cycle (load gone) all 0; stall_cnt=1.
- Multi-cycle: mc_start_E=1, mc_lat_E=4 -> StallF/D/E=1 and FlushW=1 for 3 cycles, mc_busy high for 3 cycles, then release; stall_cnt=3. mc_lat_E=1 -> no stall.
- Branch: branch_taken_E=1 together with a load-use condition -> FlushD=FlushE=1, StallF=0; flush_cnt=1.
- Reset mid-op: assert reset in the 2nd BUSY cycle of a lat=8 op -> all outputs 0 asynchronously; after deassert FSM=IDLE and counters=0.
- Saturation: PERF_W=3, hold 10 cycles of a lat=12 op -> stall_cnt sticks at 7.
